wb_drain_monitor: RTL
=====================

WB_DRAIN_MONITOR -- requirements
Module: wb_drain_monitor

Interface
REQ-001 SHALL have parameter NUM_CELLS, default 64, number of PEs/ring nodes.
REQ-002 SHALL have parameter DRAIN_MODE, default 0, selecting the drain criterion: 0 = fixed cycle countdown, 1 = in-flight packet count.
REQ-003 SHALL have parameter DRAIN_CYCLES, default NUM_CELLS, the mode-0 drain wait in cycles (>=1).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 4096, the mode-1 drain watchdog limit (>=1).
REQ-005 SHALL have parameter CNT_WIDTH, default 16, width of the in-flight and drain counters.
REQ-006 SHALL have the following ports, one per line as name  direction  width  meaning:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- ref_wb_issued  input  NUM_CELLS  per-PE pulse: ref-particle force writeback issued.
- goto_next_ref  input  1  broadcast controller advancing to the next reference particle.
- pkt_inject  input  NUM_CELLS  per-node packet accepted into the ring (valid & ready).
- pkt_eject  input  NUM_CELLS  per-node packet delivered to a force cache.
- force_cache_input_buffer_empty  input  1  all force-cache input buffers empty.
- all_filter_buffer_empty  input  1  all PE filter buffers empty.
- all_reading_done  input  1  all PEs finished reading.
- all_ref_wb_issued  output  1  every PE has issued its writeback in this round.
- interconnect_empty  output  1  ring is judged drained.
- all_force_wr_issued  output  1  every force write has completed.
- motion_update_start  output  1  single-cycle pulse that starts motion update.
- inflight_count  output  CNT_WIDTH  packets currently in the ring.
- drain_timeout  output  1  sticky watchdog flag.
- inflight_underflow  output  1  sticky flag: more ejects than injects were seen.

Function
REQ-007 SHALL hold a capture mask cap[NUM_CELLS]: cap[k] is set on ref_wb_issued[k]; bits are cleared only on leaving the EMPTY state or on an abort.
REQ-008 SHALL implement FSM states COLLECT, DRAIN, EMPTY; after reset the FSM is in COLLECT.
REQ-009 In COLLECT, when (cap | ref_wb_issued) is all ones, the FSM SHALL go to DRAIN on the next edge, with the drain counter loaded to 0; a same-cycle final pulse therefore needs no extra cycle.
REQ-010 In DRAIN, mode 0: the drain counter SHALL increment each cycle; the FSM goes to EMPTY on the edge where the counter equals DRAIN_CYCLES-1.
REQ-011 In DRAIN, mode 1: the FSM SHALL go to EMPTY when the next inflight_count is 0.
REQ-012 In DRAIN, mode 1: the drain counter increments each cycle; reaching TIMEOUT_CYCLES-1 SHALL set drain_timeout and force EMPTY.
REQ-013 goto_next_ref in DRAIN SHALL abort to COLLECT, clearing cap and the drain counter.
REQ-014 goto_next_ref in EMPTY SHALL go to COLLECT and clear cap.
REQ-015 Absent goto_next_ref, EMPTY SHALL be held.
REQ-016 goto_next_ref in COLLECT SHALL be ignored.
REQ-017 all_ref_wb_issued SHALL be 1 in DRAIN and EMPTY, and 0 in COLLECT.
REQ-018 interconnect_empty SHALL be 1 exactly in EMPTY.
REQ-019 inflight_count SHALL update every cycle, in any state, to inflight_count + popcount(pkt_inject) - popcount(pkt_eject).
REQ-020 If that inflight_count result would go negative, it SHALL clamp to 0 and set inflight_underflow.
REQ-021 If that inflight_count result would exceed 2^CNT_WIDTH-1, it SHALL saturate.
REQ-022 all_force_wr_issued SHALL be combinational, equal to (pkt_eject==0) & force_cache_input_buffer_empty & all_filter_buffer_empty & interconnect_empty.
REQ-023 motion_update_start SHALL be a registered pulse, asserted for one cycle on the cycle after all_reading_done & all_force_wr_issued first becomes true within an EMPTY visit.
REQ-024 motion_update_start SHALL fire at most once per EMPTY visit and re-arm on leaving EMPTY.
REQ-025 Latency: the last capture pulse leads to interconnect_empty 1 in mode 0 after DRAIN_CYCLES+1 edges.

Reset
REQ-026 On rst=1 at an edge, the following SHALL happen regardless of state: FSM->COLLECT; cap, drain counter, inflight_count = 0; drain_timeout, inflight_underflow, motion_update_start = 0; the re-arm flag is set.
REQ-027 During and directly after reset, all_ref_wb_issued, interconnect_empty and all_force_wr_issued SHALL read 0.
REQ-028 Reset asserted mid-DRAIN SHALL discard all partial captures; inputs in the reset cycle are ignored.

Verification
REQ-029 Mode-0 basic: NUM_CELLS=4, DRAIN_CYCLES=4, ref_wb_issued pulses 0001, 0010, 1100 on cycles 1-3 -> all_ref_wb_issued=1 from cycle 4, interconnect_empty=1 from cycle 8.
REQ-030 Mode-1 drain: 3 injects on cycle 2, ejects 1/1/1 on cycles 5-7, all PEs captured by cycle 3 -> inflight_count 3,3,3,2,1,0; EMPTY entered at the edge ending cycle 7.
REQ-031 Abort: goto_next_ref asserted in the second DRAIN cycle -> COLLECT the next cycle, cap=0, interconnect_empty never 1.
REQ-032 Timeout: mode 1, TIMEOUT_CYCLES=8, 1 packet never ejected -> drain_timeout=1 and EMPTY after 8 DRAIN cycles; drain_timeout stays 1 until rst.
REQ-033 Underflow: pkt_eject=0001 with inflight_count=0 -> inflight_count stays 0, inflight_underflow=1.
REQ-034 MU start: EMPTY with all_reading_done and both buffer-empty inputs held high for 10 cycles -> exactly one motion_update_start pulse; after goto_next_ref and a new round, exactly one more.

Source files
------------

// File: rtl/wb_drain_monitor.sv
// Tracks per-PE reference writebacks, waits for the ring to drain (fixed countdown or
// in-flight packet count), then fires a single motion-update start per EMPTY visit.
module wb_drain_monitor #(
  parameter int NUM_CELLS      = 64,
  parameter int DRAIN_MODE     = 0,
  parameter int DRAIN_CYCLES   = NUM_CELLS,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CELLS-1:0] ref_wb_issued,
  input  logic                 goto_next_ref,
  input  logic [NUM_CELLS-1:0] pkt_inject,
  input  logic [NUM_CELLS-1:0] pkt_eject,
  input  logic                 force_cache_input_buffer_empty,
  input  logic                 all_filter_buffer_empty,
  input  logic                 all_reading_done,
  output logic                 all_ref_wb_issued,
  output logic                 interconnect_empty,
  output logic                 all_force_wr_issued,
  output logic                 motion_update_start,
  output logic [CNT_WIDTH-1:0] inflight_count,
  output logic                 drain_timeout,
  output logic                 inflight_underflow
);

  localparam int PopW = $clog2(NUM_CELLS + 1);
  localparam int SumW = ((CNT_WIDTH > PopW) ? CNT_WIDTH : PopW) + 2;
  localparam logic signed [SumW-1:0] CntMax = {{(SumW-CNT_WIDTH){1'b0}}, {CNT_WIDTH{1'b1}}};
  localparam logic [CNT_WIDTH-1:0] DrainLast   = CNT_WIDTH'(DRAIN_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TimeoutLast = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {COLLECT, DRAIN, EMPTY} state_t;

  state_t                 state_q;
  logic [NUM_CELLS-1:0]   cap_q;
  logic [CNT_WIDTH-1:0]   drainCnt_q;
  logic [CNT_WIDTH-1:0]   inflight_q;
  logic [CNT_WIDTH-1:0]   inflight_d;
  logic                   timeout_q;
  logic                   underflow_q;
  logic                   muStart_q;
  logic                   armed_q;
  logic                   underflowNow;
  logic                   capAll;
  logic [PopW-1:0]        injCount;
  logic [PopW-1:0]        ejCount;
  logic signed [SumW-1:0] inflightSum;

  function automatic logic [PopW-1:0] popcount(input logic [NUM_CELLS-1:0] v);
    logic [PopW-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_CELLS; i++) n = n + PopW'(v[i]);
    return n;
  endfunction

  assign injCount    = popcount(pkt_inject);
  assign ejCount     = popcount(pkt_eject);
  assign inflightSum = $signed(SumW'(inflight_q)) + $signed(SumW'(injCount))
                     - $signed(SumW'(ejCount));
  assign capAll      = &(cap_q | ref_wb_issued);

  // Net in-flight change is evaluated in a wider signed domain so both clamp directions are exact.
  always_comb begin
    underflowNow = 1'b0;
    inflight_d   = inflightSum[CNT_WIDTH-1:0];
    if (inflightSum[SumW-1]) begin
      inflight_d   = '0;
      underflowNow = 1'b1;
    end else if (inflightSum > CntMax) begin
      inflight_d = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= COLLECT;
      cap_q       <= '0;
      drainCnt_q  <= '0;
      inflight_q  <= '0;
      timeout_q   <= 1'b0;
      underflow_q <= 1'b0;
      muStart_q   <= 1'b0;
      armed_q     <= 1'b1;
    end else begin
      inflight_q <= inflight_d;
      if (underflowNow) underflow_q <= 1'b1;
      muStart_q <= 1'b0;
      cap_q     <= cap_q | ref_wb_issued;
      case (state_q)
        COLLECT: begin
          if (capAll) begin
            state_q    <= DRAIN;
            drainCnt_q <= '0;
          end
        end
        DRAIN: begin
          if (goto_next_ref) begin
            state_q    <= COLLECT;
            cap_q      <= '0;
            drainCnt_q <= '0;
          end else begin
            drainCnt_q <= drainCnt_q + CNT_WIDTH'(1);
            if (DRAIN_MODE == 0) begin
              if (drainCnt_q == DrainLast) state_q <= EMPTY;
            end else if (inflight_d == '0) begin
              state_q <= EMPTY;
            end else if (drainCnt_q == TimeoutLast) begin
              timeout_q <= 1'b1;
              state_q   <= EMPTY;
            end
          end
        end
        EMPTY: begin
          if (armed_q && all_reading_done && all_force_wr_issued) begin
            muStart_q <= 1'b1;
            armed_q   <= 1'b0;
          end
          if (goto_next_ref) begin
            state_q <= COLLECT;
            cap_q   <= '0;
            armed_q <= 1'b1;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign all_ref_wb_issued   = (state_q != COLLECT);
  assign interconnect_empty  = (state_q == EMPTY);
  assign all_force_wr_issued = (pkt_eject == '0) & force_cache_input_buffer_empty
                             & all_filter_buffer_empty & interconnect_empty;
  assign motion_update_start = muStart_q;
  assign inflight_count      = inflight_q;
  assign drain_timeout       = timeout_q;
  assign inflight_underflow  = underflow_q;

endmodule
